fft_out_serializer: RTL and testbench

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_bitrev_idx.sv | 17 +
 rtl/fft_out_serializer.sv | 122 ++++++++++++
 tb/tb_fft_out_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT output serializer.
package fft_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_DW    = 8;
  localparam int unsigned FFT_LOG2N = 5;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/fft_bitrev_idx.sv
// Combinational bit reversal of an index over `width` bits.
module fft_bitrev_idx #(
  parameter int unsigned width = 5
) (
  input  logic [width-1:0] idx,
  output logic [width-1:0] rev_idx
);

  // Mirror the index bits: MSB of idx becomes LSB of rev_idx.
  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < width; i++) begin
      rev_idx[i] = idx[width-1-i];
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Captures a parallel FFT frame and streams it out one complex sample per
// output handshake. Optional macro FFT_OUT_BITREV_EN reads the buffer in
// bit-reversed address order so a bit-reversed FFT result leaves in natural order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned data_width = FFT_DW,
  parameter int unsigned no_in_out  = FFT_N
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [no_in_out*data_width-1:0]   input_data_real,
  input  logic [no_in_out*data_width-1:0]   input_data_imag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [data_width-1:0]             out_real,
  output logic [data_width-1:0]             out_imag,
  output logic [$clog2(no_in_out)-1:0]      out_index,
  output logic                              out_last,
  output logic                              frame_done
);

  localparam int unsigned   IdxW    = $clog2(no_in_out);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(no_in_out - 1);
`ifdef FFT_OUT_BITREV_EN
  localparam bit BitrevEn = 1'b1;
`else
  localparam bit BitrevEn = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [IdxW-1:0]   count_q, count_d;
  logic              frame_done_q, frame_done_d;
  logic [data_width-1:0] buf_real_q [no_in_out];
  logic [data_width-1:0] buf_imag_q [no_in_out];

  logic            is_last;
  logic            in_hs;
  logic            out_hs;
  logic [IdxW-1:0] rev_count;
  logic [IdxW-1:0] addr;

  fft_bitrev_idx #(
    .width (IdxW)
  ) u_bitrev (
    .idx     (count_q),
    .rev_idx (rev_count)
  );

  // Handshake decode shared by the next-state and output logic.
  always_comb begin
    is_last = (state_q == STREAM) && (count_q == LastIdx);
    // Accept a new frame while idle, or on the last sample's handshake.
    in_ready = (state_q == IDLE) || (is_last && out_ready);
    in_hs    = in_valid && in_ready;
    out_hs   = (state_q == STREAM) && out_ready;
    addr     = BitrevEn ? rev_count : count_q;
  end

  // State, sample counter and frame_done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame buffer; not reset since it is only visible while streaming.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int k = 0; k < int'(no_in_out); k++) begin
        buf_real_q[k] <= input_data_real[k*data_width +: data_width];
        buf_imag_q[k] <= input_data_imag[k*data_width +: data_width];
      end
    end
  end

  // Next-state logic: count advances only on output handshakes.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = STREAM;
          count_d = '0;
        end
      end
      STREAM: begin
        if (out_hs) begin
          if (is_last) begin
            frame_done_d = 1'b1;
            count_d      = '0;
            // in_hs is implied here when in_valid is high.
            state_d      = in_valid ? STREAM : IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Output logic: data and index are forced to zero when not streaming.
  always_comb begin
    out_valid  = (state_q == STREAM);
    out_last   = is_last;
    frame_done = frame_done_q;
    out_index  = out_valid ? count_q : '0;
    out_real   = out_valid ? buf_real_q[addr] : '0;
    out_imag   = out_valid ? buf_imag_q[addr] : '0;
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed, table-driven bench for fft_out_serializer (N=32, DW=8).
// Expected sample order follows FFT_OUT_BITREV_EN if defined for the build.
module tb_fft_out_serializer;

  localparam int N  = 32;
  localparam int DW = 8;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] data_real = '0;
  logic [N*DW-1:0] data_imag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_real;
  logic [DW-1:0]   out_imag;
  logic [LW-1:0]   out_index;
  logic            out_last;
  logic            frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  fft_out_serializer #(
    .data_width (DW),
    .no_in_out  (N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .input_data_real (data_real),
    .input_data_imag (data_imag),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_real        (out_real),
    .out_imag        (out_imag),
    .out_index       (out_index),
    .out_last        (out_last),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic          check;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic          exp_last;
    logic          exp_done;
    logic [DW-1:0] exp_real;
    logic [DW-1:0] exp_imag;
    logic [LW-1:0] exp_index;
  } vec_t;

  vec_t vt[37];

  function automatic int addr_of(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r = 0;
    for (int i = 0; i < LW; i++) if (k[i]) r = r | (1 << (LW - 1 - i));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_re(input int base, input int k);
    return DW'(base + addr_of(k));
  endfunction

  function automatic logic [DW-1:0] exp_im(input int k);
    return DW'(0 - addr_of(k));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame pattern: real[k] = base+k, imag[k] = -k.
  task automatic load_frame(input int base);
    for (int k = 0; k < N; k++) begin
      data_real[k*DW +: DW] = DW'(base + k);
      data_imag[k*DW +: DW] = DW'(0 - k);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input int k, input int base,
                            input logic rdy, input logic done);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, "_done"}, 32'(frame_done), 32'(done));
    if (v) begin
      chk({tag, "_index"}, 32'(out_index), 32'(k));
      chk({tag, "_real"}, 32'(out_real), 32'(exp_re(base, k)));
      chk({tag, "_imag"}, 32'(out_imag), 32'(exp_im(k)));
      chk({tag, "_last"}, 32'(out_last), 32'(k == N - 1));
    end else begin
      chk({tag, "_index"}, 32'(out_index), 32'd0);
      chk({tag, "_real"}, 32'(out_real), 32'd0);
      chk({tag, "_imag"}, 32'(out_imag), 32'd0);
      chk({tag, "_last"}, 32'(out_last), 32'd0);
    end
  endtask

  // Present a frame with in_valid for one cycle; DUT must be ready.
  task automatic start_frame(input int base);
    @(negedge clk);
    rst = 1'b0;
    load_frame(base);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic pat [4];
    int   exp_k;
    int   cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // ---- Table: reset, then one frame at full throughput ----
    for (int i = 0; i < 37; i++) begin
      vt[i] = '{rst: 1'b0, in_valid: 1'b0, out_ready: 1'b1, check: 1'b1,
                exp_in_ready: 1'b1, exp_out_valid: 1'b0, exp_last: 1'b0, exp_done: 1'b0,
                exp_real: '0, exp_imag: '0, exp_index: '0};
    end
    vt[0].rst = 1'b1; vt[0].check = 1'b0;
    vt[1].rst = 1'b1; vt[1].out_ready = 1'b0;
    vt[2].in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      vt[3+k].exp_out_valid = 1'b1;
      vt[3+k].exp_in_ready  = (k == N - 1);
      vt[3+k].exp_last      = (k == N - 1);
      vt[3+k].exp_real      = exp_re(0, k);
      vt[3+k].exp_imag      = exp_im(k);
      vt[3+k].exp_index     = LW'(k);
    end
    vt[35].exp_done = 1'b1;

    load_frame(0);
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      rst       = vt[i].rst;
      in_valid  = vt[i].in_valid;
      out_ready = vt[i].out_ready;
      #1;
      if (vt[i].check) begin
        chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_in_ready));
        chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_out_valid));
        chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(vt[i].exp_last));
        chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(vt[i].exp_done));
        chk($sformatf("tbl%0d_real", i), 32'(out_real), 32'(vt[i].exp_real));
        chk($sformatf("tbl%0d_imag", i), 32'(out_imag), 32'(vt[i].exp_imag));
        chk($sformatf("tbl%0d_index", i), 32'(out_index), 32'(vt[i].exp_index));
      end
    end

    // ---- Backpressure: out_ready pattern 1,0,0,1 ----
    start_frame(0);
    exp_k = 0;
    cyc   = 0;
    while (exp_k < N && cyc < 200) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = pat[cyc % 4];
      #1;
      expect_out($sformatf("stall_c%0d", cyc), 1'b1, exp_k, 0,
                 out_ready && (exp_k == N - 1), 1'b0);
      if (out_ready) exp_k++;
      cyc++;
    end
    chk("stall_all_delivered", 32'(exp_k), 32'(N));
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    expect_out("stall_end", 1'b0, 0, 0, 1'b1, 1'b1);

    // ---- Back-to-back frames with in_valid held high ----
    start_frame(0);
    for (int j = 0; j < 2 * N; j++) begin
      @(negedge clk);
      load_frame(100);
      in_valid = (j < 2 * N - 1);
      #1;
      expect_out($sformatf("b2b_j%0d", j), 1'b1, j % N, (j < N) ? 0 : 100,
                 (j % N) == N - 1, j == N);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    expect_out("b2b_end", 1'b0, 0, 0, 1'b1, 1'b1);

    // ---- in_valid pulsed mid-frame is ignored ----
    start_frame(0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == 10) load_frame(200);
      in_valid = (k == 10);
      #1;
      expect_out($sformatf("ign_k%0d", k), 1'b1, k, 0, k == N - 1, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    expect_out("ign_end", 1'b0, 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    expect_out("ign_idle", 1'b0, 0, 0, 1'b1, 1'b0);

    // ---- Reset mid-frame at count 15 ----
    start_frame(0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      rst      = (k == 15);
      #1;
      expect_out($sformatf("rst_k%0d", k), 1'b1, k, 0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_out("rst_after", 1'b0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    expect_out("rst_after2", 1'b0, 0, 0, 1'b1, 1'b0);
    start_frame(50);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      expect_out($sformatf("new_k%0d", k), 1'b1, k, 50, k == N - 1, 1'b0);
    end
    @(negedge clk);
    #1;
    expect_out("new_end", 1'b0, 0, 0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
